// File: rtl/relu_maxpool.sv
// Post-convolution ReLU + 2x2 max pooling stage: reads BRAM2 two rows at a time
// and streams one 64-element pooled row per row pair over valid/ready.
module relu_maxpool #(
    parameter int ROWS = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [7:0]    rd_addr,
    input  logic [1023:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [511:0]  out_data,
    output logic [6:0]    out_row,
    output logic          busy,
    output logic          done
);

    localparam logic [6:0] LAST_R = 7'(ROWS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      r_q, r_d;
    logic [1023:0]   row_a_q, row_a_d;
    logic            rd_en_q, rd_en_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic            out_valid_q, out_valid_d;
    logic [511:0]    out_data_q, out_data_d;
    logic [6:0]      out_row_q, out_row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    function automatic logic [7:0] relu8(input logic [7:0] x);
        return x[7] ? 8'h00 : x;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Element j pools the 2x2 window made of columns 2j, 2j+1 of rows A and B.
    function automatic logic [511:0] pool_rows(input logic [1023:0] a, input logic [1023:0] b);
        logic [511:0] res;
        res = 512'd0;
        for (int j = 0; j < 64; j++) begin
            res[8*j +: 8] = max8(max8(relu8(a[16*j +: 8]), relu8(a[16*j+8 +: 8])),
                                 max8(relu8(b[16*j +: 8]), relu8(b[16*j+8 +: 8])));
        end
        return res;
    endfunction

    // Next-state logic; outputs are derived from the next state so they come out of flops.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        row_a_d    = row_a_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = 7'd0;
                    state_d = FETCH_A;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: begin
                row_a_d = rd_data;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                out_data_d = pool_rows(row_a_q, rd_data);
                out_row_d  = r_q;
                state_d    = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready && (r_q == LAST_R)) begin
                    state_d = DONE;
                end else if (out_ready) begin
                    r_d     = r_q + 7'd1;
                    state_d = FETCH_A;
                end else begin
                    state_d = OUTPUT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d     = (state_d == FETCH_A) || (state_d == FETCH_B);
        out_valid_d = (state_d == OUTPUT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        if (state_d == FETCH_A) begin
            rd_addr_d = {r_d, 1'b0};
        end else if (state_d == FETCH_B) begin
            rd_addr_d = {r_d, 1'b1};
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= 7'd0;
            row_a_q     <= 1024'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 512'd0;
            out_row_q   <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            row_a_q     <= row_a_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: a ROWS=128 and a ROWS=2 instance share a
// BRAM model; results are compared with an arithmetic reference of ReLU + 2x2 max.
`timescale 1ns/1ps
module tb_relu_maxpool;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, start2;
    logic          out_ready, out_ready2;
    logic          rd_en, rd_en2;
    logic [7:0]    rd_addr, rd_addr2;
    logic [1023:0] rd_data, rd_data2;
    logic          out_valid, out_valid2;
    logic [511:0]  out_data, out_data2;
    logic [6:0]    out_row, out_row2;
    logic          busy, busy2, done, done2;

    logic [1023:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    relu_maxpool #(.ROWS(128)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .busy(busy), .done(done)
    );

    relu_maxpool #(.ROWS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_row(out_row2), .busy(busy2), .done(done2)
    );

    // BRAM2 model with one cycle of read latency
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en2) rd_data2 <= mem[rd_addr2];
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pool_ref(input int r);
        logic [511:0] res;
        logic [7:0]   b;
        int           v, m;
        res = '0;
        for (int j = 0; j < 64; j++) begin
            m = 0;
            for (int k = 0; k < 4; k++) begin
                b = mem[2*r + k/2][8*(2*j + k%2) +: 8];
                v = (b >= 8'd128) ? int'(b) - 256 : int'(b);
                if (v < 0) v = 0;
                if (v > m) m = v;
            end
            res[8*j +: 8] = 8'(m);
        end
        return res;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++)
            for (int w = 0; w < 32; w++)
                mem[i][32*w +: 32] = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_en"}, rd_en, 512'd0);
        check_eq({tag, "_rd_addr"}, rd_addr, 512'd0);
        check_eq({tag, "_out_valid"}, out_valid, 512'd0);
        check_eq({tag, "_out_data"}, out_data, 512'd0);
        check_eq({tag, "_out_row"}, out_row, 512'd0);
        check_eq({tag, "_busy"}, busy, 512'd0);
        check_eq({tag, "_done"}, done, 512'd0);
    endtask

    initial begin
        logic [511:0] exp_row, held;
        bit           exp_valid;

        // Reset with random inputs on both instances
        rst = 1'b1;
        start = 1'($urandom); start2 = 1'($urandom);
        out_ready = 1'($urandom); out_ready2 = 1'($urandom);
        fill_random();
        tick();
        start = 1'($urandom); start2 = 1'($urandom);
        out_ready = 1'($urandom); out_ready2 = 1'($urandom);
        tick();
        rst = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        check_idle_outputs("reset");
        check_eq("reset_out_valid2", out_valid2, 512'd0);
        check_eq("reset_out_data2", out_data2, 512'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("idle_rd_en", rd_en, 512'd0);
            check_eq("idle_rd_en2", rd_en2, 512'd0);
        end

        // Single pair with ROWS=2, including an all-negative group at j=3
        for (int i = 0; i < 2; i++)
            for (int e = 0; e < 128; e++)
                mem[i][8*e +: 8] = 8'h01;
        mem[0][7:0] = 8'h10; mem[0][15:8] = 8'hF0;
        mem[1][7:0] = 8'h05; mem[1][15:8] = 8'h7F;
        mem[0][55:48] = 8'h80; mem[0][63:56] = 8'hFF;
        mem[1][55:48] = 8'h81; mem[1][63:56] = 8'hC0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check_eq("sp_c1_rd_en", rd_en2, 512'd1);
        check_eq("sp_c1_rd_addr", rd_addr2, 512'd0);
        check_eq("sp_c1_busy", busy2, 512'd1);
        tick();
        check_eq("sp_c2_rd_addr", rd_addr2, 512'd1);
        tick();
        check_eq("sp_c3_rd_en", rd_en2, 512'd0);
        check_eq("sp_c3_out_valid", out_valid2, 512'd0);
        tick();
        check_eq("sp_c4_out_valid", out_valid2, 512'd1);
        check_eq("sp_c4_elem0", out_data2[7:0], 512'h7F);
        check_eq("sp_c4_relu_j3", out_data2[31:24], 512'h00);
        check_eq("sp_c4_elem1", out_data2[15:8], 512'h01);
        check_eq("sp_c4_model", out_data2, pool_ref(0));
        check_eq("sp_c4_out_row", out_row2, 512'd0);
        check_eq("sp_c4_done", done2, 512'd0);
        tick();
        check_eq("sp_c5_done", done2, 512'd1);
        check_eq("sp_c5_out_valid", out_valid2, 512'd0);
        tick();
        check_eq("sp_c6_done", done2, 512'd0);
        check_eq("sp_c6_busy", busy2, 512'd0);

        // Backpressure: out_ready low for the first five OUTPUT cycles
        fill_random();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        held = pool_ref(0);
        for (int c = 4; c <= 8; c++) begin
            check_eq("bp_out_valid", out_valid, 512'd1);
            check_eq("bp_out_data", out_data, held);
            check_eq("bp_out_row", out_row, 512'd0);
            check_eq("bp_rd_en", rd_en, 512'd0);
            tick();
        end
        out_ready = 1'b1;
        check_eq("bp_c9_out_valid", out_valid, 512'd1);
        check_eq("bp_c9_rd_en", rd_en, 512'd0);
        tick();
        check_eq("bp_c10_rd_en", rd_en, 512'd1);
        check_eq("bp_c10_rd_addr", rd_addr, 512'd2);
        check_eq("bp_c10_out_valid", out_valid, 512'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("bp_abort");

        // Reset in cycle 50 of a pass
        fill_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 50; c++) tick();
        check_eq("mid_c50_busy", busy, 512'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        for (int c = 0; c < 8; c++) begin
            tick();
            check_eq("mid_no_done", done, 512'd0);
            check_eq("mid_no_rd_en", rd_en, 512'd0);
        end

        // Full pass restart, with an ignored start pulse in cycle 100
        fill_random();
        start = 1'b1;
        for (int c = 1; c <= 262; c++) begin
            tick();
            if (c == 1 || c == 101) start = 1'b0;
            if (c == 100) start = 1'b1;
            exp_valid = (c >= 4) && (c <= 256) && (c % 4 == 0);
            check_eq("fp_out_valid", out_valid, {511'd0, exp_valid});
            check_eq("fp_done", done, {511'd0, c == 257});
            check_eq("fp_busy", busy, {511'd0, (c >= 1) && (c <= 257)});
            if ((c % 4 == 1) && (c <= 253)) begin
                check_eq("fp_rd_en", rd_en, 512'd1);
                check_eq("fp_rd_addr", rd_addr, 512'(2 * ((c - 1) / 4)));
            end
            if (exp_valid) begin
                exp_row = pool_ref((c - 4) / 4);
                check_eq("fp_out_row", out_row, 512'((c - 4) / 4));
                check_eq("fp_out_data", out_data, exp_row);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Post-convolution stage that runs once the convolution pass has filled the result BRAM (BRAM2) and raised `conv_done`. It reads BRAM2 two rows at a time and applies ReLU to every signed 8-bit element. It then performs 2x2 max pooling, reducing each row pair of 128 elements to one 64-element output row. Output rows are delivered over a valid/ready stream to the next stage.

## Interface
- `ROWS`, 128: number of valid BRAM2 rows to process; even, 2..256.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a pass; tie to `conv_done`; sampled only in IDLE.
- `rd_en` out 1: BRAM2 port enable for this block's read.
- `rd_addr` out 8: BRAM2 row address.
- `rd_data` in 1024: BRAM2 read data; valid the cycle after `rd_en`/`rd_addr` are presented (1-cycle latency).
- `out_valid` out 1: `out_data` holds a pooled row.
- `out_ready` in 1: consumer accepts when high with `out_valid`.
- `out_data` out 512: 64 pooled elements, element j at [8j+7:8j], unsigned 0..127.
- `out_row` out 7: index of the pooled row on `out_data` (0..ROWS/2-1).
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse after the final row handshake.

## Operation
- Element i of a 1024-bit row is at [8i+7:8i], two's-complement signed.
- ReLU: a negative element becomes 0x00; others pass unchanged.
- Pooling for pair r:
  - Row A is address 2r; row B is address 2r+1.
  - out element j = max(relu(A[2j]), relu(A[2j+1]), relu(B[2j]), relu(B[2j+1])).
  - Comparison is unsigned, applied after ReLU.
- Pair counter r runs 0..ROWS/2-1.
- FSM states:
  - IDLE: `rd_en`=0. If `start`=1, set r=0 and go to FETCH_A. Otherwise stay.
  - FETCH_A: `rd_en`=1, `rd_addr`=2r. Go to FETCH_B.
  - FETCH_B: `rd_en`=1, `rd_addr`=2r+1. Register `rd_data` as row A. Go to CAPTURE.
  - CAPTURE: `rd_en`=0. Combine `rd_data` (row B) with registered row A. Register the pooled result into `out_data` and `out_row`=r. Go to OUTPUT.
  - OUTPUT: `out_valid`=1, with `out_data` and `out_row` held stable.
    - If `out_ready`=1 and r=ROWS/2-1, go to DONE.
    - If `out_ready`=1 and r<ROWS/2-1, increment r and go to FETCH_A.
    - Otherwise stay in OUTPUT.
  - DONE: `done`=1 for this one cycle, then go to IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- `out_data` and `out_row` keep their last value after the handshake until the next CAPTURE overwrites them.
- `rd_addr` holds its last value when `rd_en`=0.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_row`=0, `busy`=0, `done`=0. FSM in IDLE, r=0.
- `rst` at any state, including mid-pass or in OUTPUT, returns to IDLE on the next edge. The current output row is discarded; no `done` pulse is produced.
- Numbering: `start` high in cycle 0 (FSM in IDLE).
- Cycle 1 is FETCH_A, cycle 2 FETCH_B, cycle 3 CAPTURE, cycle 4 is the first `out_valid`.
- With `out_ready` held high, each pair takes exactly 4 cycles; pair k has `out_valid` in cycle 4k+4.
- Backpressure:
  - Each cycle `out_ready`=0 in OUTPUT adds one cycle.
  - BRAM2 is not read while stalled.
- Full default pass (ROWS=128, `out_ready`=1):
  - 64 output rows.
  - Last `out_valid` in cycle 256; `done` in cycle 257; `busy` high cycles 1..257.
- `start` high in the same cycle as a DONE state: ignored, because DONE is not IDLE. A new pass needs `start` in a later cycle.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs. Afterwards every output is 0 and no `rd_en` appears while `start`=0.
- Single pair, ROWS=2: row0 bytes [0]=0x10, [1]=0xF0; row1 [0]=0x05, [1]=0x7F; all other bytes 0x01.
  - `out_data[7:0]`=0x7F and every other element is 0x01.
  - `out_valid` in cycle 4; `done` in cycle 5.
  - `rd_addr` reads 0 then 1.
- ReLU: all four bytes of group j=3 are negative (0x80, 0xFF, 0x81, 0xC0). `out_data[31:24]`=0x00.
- Backpressure: hold `out_ready`=0 for 5 cycles at the first OUTPUT.
  - `out_valid`, `out_data` and `out_row` stay stable.
  - `rd_en` stays 0.
  - The next FETCH_A begins the cycle after `out_ready` rises.
- Full pass, ROWS=128, `out_ready`=1, random BRAM contents:
  - 64 rows match the reference model, with `out_row` 0..63 in order.
  - `done` appears only in cycle 257.
  - A second `start` pulse in cycle 100 is ignored.
- Reset mid-pass: assert `rst` in cycle 50 (pair 12).
  - Outputs return to reset values and no `done` pulse occurs.
  - A new `start` restarts from `rd_addr`=0 with `out_row`=0.
